// File: rtl/led_seq_driver.sv
// rtl/led_seq_driver.sv - command-driven LED driver: timed flash with trailing gap, steady, all-on flash, clear
module led_seq_driver #(
  parameter int NUM_LEDS   = 4,
  parameter int SEL_WIDTH  = $clog2(NUM_LEDS),
  parameter int DUR_WIDTH  = 16,
  parameter int GAP_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_mode,
  input  logic [SEL_WIDTH-1:0] cmd_led,
  input  logic [DUR_WIDTH-1:0] cmd_dur,
  output logic [NUM_LEDS-1:0]  leds,
  output logic                 done,
  output logic                 err
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int CNT_W = (DUR_WIDTH > GAP_W) ? DUR_WIDTH : GAP_W;

  localparam logic [1:0] MODE_CLEAR     = 2'b00;
  localparam logic [1:0] MODE_FLASH     = 2'b01;
  localparam logic [1:0] MODE_STEADY    = 2'b10;
  localparam logic [1:0] MODE_FLASH_ALL = 2'b11;

  localparam logic [CNT_W-1:0]    GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [NUM_LEDS-1:0] LED_ONE  = {{(NUM_LEDS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_LEDS-1:0]   leds_q, leds_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic                  led_oob;
  logic [NUM_LEDS-1:0]   led_onehot;
  logic [CNT_W-1:0]      dur_load;

  assign accept     = cmd_valid && cmd_ready_q;
  assign led_oob    = {1'b0, cmd_led} >= (SEL_WIDTH+1)'(NUM_LEDS);
  assign led_onehot = LED_ONE << cmd_led;
  // A zero duration is stretched to a single lit cycle.
  assign dur_load   = (cmd_dur == '0) ? '0 : CNT_W'(cmd_dur - DUR_WIDTH'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    leds_d  = leds_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cmd_mode != MODE_CLEAR && led_oob) begin
            leds_d = '0;
            err_d  = 1'b1;
          end else begin
            case (cmd_mode)
              MODE_CLEAR:  leds_d = '0;
              MODE_STEADY: leds_d = led_onehot;
              MODE_FLASH: begin
                leds_d  = led_onehot;
                state_d = S_ON;
                cnt_d   = dur_load;
              end
              MODE_FLASH_ALL: begin
                leds_d  = '1;
                state_d = S_ON;
                cnt_d   = dur_load;
              end
              default: leds_d = '0;
            endcase
          end
        end
      end
      S_ON: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          leds_d = '0;
          if (GAP_CYCLES > 0) begin
            state_d = S_GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_GAP: begin
        leds_d = '0;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        leds_d  = '0;
      end
    endcase
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      leds_q      <= '0;
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      leds_q      <= leds_d;
      cmd_ready_q <= cmd_ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign leds      = leds_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_led_seq_driver.sv
// tb/tb_led_seq_driver.sv - directed self-checking bench for led_seq_driver
module tb_led_seq_driver;

  localparam logic [1:0] CLR = 2'b00;
  localparam logic [1:0] FLS = 2'b01;
  localparam logic [1:0] STD = 2'b10;
  localparam logic [1:0] ALL = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        a_valid, a_ready, a_done, a_err;
  logic [1:0]  a_mode;
  logic [2:0]  a_led;
  logic [15:0] a_dur;
  logic [3:0]  a_leds;

  logic        b_valid, b_ready, b_done, b_err;
  logic [1:0]  b_mode;
  logic [2:0]  b_led;
  logic [15:0] b_dur;
  logic [5:0]  b_leds;

  int checks = 0;
  int failures = 0;
  int a_done_cnt = 0;

  always #5 clk = ~clk;

  // Four LEDs with a 3-bit index so out-of-range indices can be driven.
  led_seq_driver #(.NUM_LEDS(4), .SEL_WIDTH(3), .DUR_WIDTH(16), .GAP_CYCLES(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(a_valid), .cmd_ready(a_ready), .cmd_mode(a_mode),
    .cmd_led(a_led), .cmd_dur(a_dur),
    .leds(a_leds), .done(a_done), .err(a_err)
  );

  led_seq_driver #(.NUM_LEDS(6), .DUR_WIDTH(16), .GAP_CYCLES(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_mode(b_mode),
    .cmd_led(b_led), .cmd_dur(b_dur),
    .leds(b_leds), .done(b_done), .err(b_err)
  );

  always @(posedge clk) begin
    #1;
    if (a_done === 1'b1) a_done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [1:0] m, input logic [2:0] l, input logic [15:0] d);
    a_valid = 1'b1; a_mode = m; a_led = l; a_dur = d;
    step();
    a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] m, input logic [2:0] l, input logic [15:0] d);
    b_valid = 1'b1; b_mode = m; b_led = l; b_dur = d;
    step();
    b_valid = 1'b0;
  endtask

  // Sample k after accept: lit for k<=n_lit, dark for 8 gap cycles, done+ready at k=n_lit+9.
  task automatic expect_flash_a(input string tag, input logic [3:0] pat, input int n_lit);
    int last;
    last = n_lit + 8 + 1;
    for (int k = 1; k <= last; k++) begin
      check(tag, 32'({a_ready, a_done, a_err, a_leds}),
            32'({(k == last), (k == last), 1'b0, ((k <= n_lit) ? pat : 4'b0000)}));
      step();
    end
    check({tag, "_pulse"}, 32'(a_done), 32'(1'b0));
  endtask

  initial begin
    int n;
    int base;
    rst_n = 1'b0;
    a_valid = 1'b0; a_mode = CLR; a_led = 3'd0; a_dur = 16'd0;
    b_valid = 1'b0; b_mode = CLR; b_led = 3'd0; b_dur = 16'd0;
    #12;
    check("rst_leds", 32'(a_leds), 32'(4'b0000));
    check("rst_ready", 32'(a_ready), 32'(1'b1));
    check("rst_done", 32'(a_done), 32'(1'b0));
    check("rst_err", 32'(a_err), 32'(1'b0));
    check("rst_b_ready", 32'(b_ready), 32'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    send_a(FLS, 3'd2, 16'd5);
    expect_flash_a("flash_led2", 4'b0100, 5);

    send_a(STD, 3'd1, 16'd0);
    check("steady", 32'({a_ready, a_leds}), 32'({1'b1, 4'b0010}));
    step(); step();
    check("steady_hold", 32'({a_ready, a_leds}), 32'({1'b1, 4'b0010}));
    send_a(FLS, 3'd3, 16'd3);
    expect_flash_a("steady_then_flash", 4'b1000, 3);

    send_a(FLS, 3'd0, 16'd0);
    expect_flash_a("dur_zero", 4'b0001, 1);
    send_a(ALL, 3'd0, 16'd2);
    expect_flash_a("flash_all", 4'b1111, 2);

    send_a(FLS, 3'd0, 16'd10);
    step(); step();
    check("pre_reset_lit", 32'(a_leds), 32'(4'b0001));
    rst_n = 1'b0;
    #1;
    check("async_rst_leds", 32'(a_leds), 32'(4'b0000));
    check("async_rst_ready", 32'(a_ready), 32'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_no_done", 32'({a_done, a_leds}), 32'(5'b0));
    send_a(FLS, 3'd1, 16'd1);
    expect_flash_a("post_rst_flash", 4'b0010, 1);

    base = a_done_cnt;
    a_valid = 1'b1; a_mode = FLS; a_dur = 16'd2;
    for (int j = 0; j < 4; j++) begin
      a_led = 3'(j);
      n = 0;
      while (!a_ready && n < 50) begin
        step();
        n++;
      end
      if (j > 0) check("b2b_wait", 32'(n), 32'(10));
      step();
      check("b2b_led", 32'(a_leds), 32'(4'b0001 << j));
    end
    a_valid = 1'b0;
    n = 0;
    while (!a_ready && n < 50) begin
      step();
      n++;
    end
    check("b2b_last_wait", 32'(n), 32'(10));
    step();
    check("b2b_done_cnt", 32'(a_done_cnt - base), 32'(4));

    send_a(STD, 3'd1, 16'd0);
    send_a(STD, 3'd5, 16'd0);
    check("oob_steady", 32'({a_ready, a_done, a_err, a_leds}), 32'({1'b1, 1'b0, 1'b1, 4'b0000}));
    step();
    check("oob_err_pulse", 32'({a_err, a_leds}), 32'(5'b0));
    send_a(FLS, 3'd7, 16'd4);
    check("oob_flash", 32'({a_ready, a_done, a_err, a_leds}), 32'({1'b1, 1'b0, 1'b1, 4'b0000}));
    step();
    check("oob_flash_idle", 32'({a_ready, a_done, a_err}), 32'(3'b100));

    send_b(STD, 3'd5, 16'd0);
    check("b_steady5", 32'({b_err, b_leds}), 32'({1'b0, 6'b100000}));
    send_b(FLS, 3'd6, 16'd3);
    check("b_oob", 32'({b_ready, b_err, b_leds}), 32'({1'b1, 1'b1, 6'b000000}));
    send_b(FLS, 3'd4, 16'd2);
    check("b_nogap_k1", 32'({b_ready, b_done, b_leds}), 32'({1'b0, 1'b0, 6'b010000}));
    step();
    check("b_nogap_k2", 32'({b_ready, b_done, b_leds}), 32'({1'b0, 1'b0, 6'b010000}));
    step();
    check("b_nogap_done", 32'({b_ready, b_done, b_err, b_leds}), 32'({1'b1, 1'b1, 1'b0, 6'b000000}));
    step();
    check("b_nogap_pulse", 32'(b_done), 32'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
